// File: rtl/fmax_reduce_if.sv
// Stream bundle for fmax_reduce: sample input handshake plus window-result output handshake.
interface fmax_reduce_if #(
  parameter int WE     = 8,
  parameter int WF     = 23,
  parameter int WINDOW = 4
);
  localparam int W  = WE + WF + 3;
  localparam int IW = $clog2(WINDOW);

  logic [W-1:0]  in_data;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  out_data;
  logic [IW-1:0] out_idx;
  logic          out_unordered;
  logic          out_valid;
  logic          out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_idx, out_unordered, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_idx, out_unordered, out_valid
  );
endinterface

// File: rtl/fmax_reduce.sv
// Streaming FloPoCo maximum over fixed windows of WINDOW samples, one sample per cycle.
// Define FMAX_REDUCE_NAN_PROPAGATE_EN to make the first NaN of a window win; otherwise NaNs are skipped.
module fmax_reduce #(
  parameter int WE     = 8,
  parameter int WF     = 23,
  parameter int WINDOW = 4
) (
  input  logic         clk,
  input  logic         rst,
  fmax_reduce_if.slave bus
);
  localparam int W  = WE + WF + 3;
  localparam int IW = $clog2(WINDOW);
  localparam logic [IW-1:0] LAST = IW'(WINDOW - 1);

  typedef enum logic [0:0] {ACCUM = 1'b0, EMIT = 1'b1} state_t;

  state_t        state_r, state_s;
  logic [IW-1:0] cnt_r, cnt_s, idx_r, idx_s, out_idx_r;
  logic [W-1:0]  acc_r, acc_s, out_data_r;
  logic          unord_r, unord_s, out_unord_r;
  logic          in_ready_s, accept_s, first_s, last_s, take_s, in_nan_s, acc_nan_s;

  function automatic logic is_nan(input logic [W-1:0] v);
    return v[W-1:W-2] == 2'b11;
  endfunction

  // Order class: -inf < negative normal < zero (either sign) < positive normal < +inf
  function automatic logic [2:0] fp_class(input logic [W-1:0] v);
    case (v[W-1:W-2])
      2'b00:   return 3'd2;
      2'b01:   return v[W-3] ? 3'd1 : 3'd3;
      2'b10:   return v[W-3] ? 3'd0 : 3'd4;
      default: return 3'd2;
    endcase
  endfunction

  function automatic logic fp_lt(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2:0] ca, cb;
    ca = fp_class(a);
    cb = fp_class(b);
    if (ca != cb) begin
      return ca < cb;
    end else if (ca == 3'd3) begin
      return a[W-4:0] < b[W-4:0];
    end else if (ca == 3'd1) begin
      return a[W-4:0] > b[W-4:0];
    end else begin
      return 1'b0;
    end
  endfunction

  assign in_ready_s = (state_r == EMIT) ? bus.out_ready : 1'b1;
  assign accept_s   = bus.in_valid && in_ready_s;
  assign first_s    = (cnt_r == {IW{1'b0}});
  assign last_s     = (cnt_r == LAST);
  assign in_nan_s   = is_nan(bus.in_data);
  assign acc_nan_s  = is_nan(acc_r);

`ifdef FMAX_REDUCE_NAN_PROPAGATE_EN
  assign take_s = first_s || (!acc_nan_s && (in_nan_s || fp_lt(acc_r, bus.in_data)));
`else
  assign take_s = first_s || (!in_nan_s && (acc_nan_s || fp_lt(acc_r, bus.in_data)));
`endif

  assign bus.in_ready      = in_ready_s;
  assign bus.out_valid     = (state_r == EMIT);
  assign bus.out_data      = out_data_r;
  assign bus.out_idx       = out_idx_r;
  assign bus.out_unordered = out_unord_r;

  // Next accumulator, winning index, sticky NaN flag and sample counter
  always_comb begin
    acc_s   = acc_r;
    idx_s   = idx_r;
    unord_s = unord_r;
    cnt_s   = cnt_r;
    if (accept_s) begin
      if (take_s) begin
        acc_s = bus.in_data;
        idx_s = cnt_r;
      end else begin
        acc_s = acc_r;
        idx_s = idx_r;
      end
      unord_s = first_s ? in_nan_s : (unord_r | in_nan_s);
      cnt_s   = last_s ? {IW{1'b0}} : (cnt_r + IW'(1));
    end else begin
      acc_s   = acc_r;
      idx_s   = idx_r;
      unord_s = unord_r;
      cnt_s   = cnt_r;
    end
  end

  // Next-state logic; EMIT leaves as soon as the consumer takes the result
  always_comb begin
    state_s = state_r;
    case (state_r)
      ACCUM: begin
        if (accept_s && last_s) begin
          state_s = EMIT;
        end else begin
          state_s = ACCUM;
        end
      end
      EMIT: begin
        if (bus.out_ready) begin
          state_s = ACCUM;
        end else begin
          state_s = EMIT;
        end
      end
      default: state_s = ACCUM;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ACCUM;
    end else begin
      state_r <= state_s;
    end
  end

  // Window datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r   <= {W{1'b0}};
      idx_r   <= {IW{1'b0}};
      unord_r <= 1'b0;
      cnt_r   <= {IW{1'b0}};
    end else begin
      acc_r   <= acc_s;
      idx_r   <= idx_s;
      unord_r <= unord_s;
      cnt_r   <= cnt_s;
    end
  end

  // Result registers capture the final window value and then hold through any stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_r  <= {W{1'b0}};
      out_idx_r   <= {IW{1'b0}};
      out_unord_r <= 1'b0;
    end else if (accept_s && last_s) begin
      out_data_r  <= acc_s;
      out_idx_r   <= idx_s;
      out_unord_r <= unord_s;
    end else begin
      out_data_r  <= out_data_r;
      out_idx_r   <= out_idx_r;
      out_unord_r <= out_unord_r;
    end
  end
endmodule
